// File: rtl/key_event_ctrl_pkg.sv
// Shared event-type codes and per-key FSM state encodings for the key event scheduler.
package key_evt_pkg;

    localparam logic [1:0] EVT_SHORT        = 2'd0;
    localparam logic [1:0] EVT_LONG         = 2'd1;
    localparam logic [1:0] EVT_REPEAT       = 2'd2;
    localparam logic [1:0] EVT_LONG_RELEASE = 2'd3;

    typedef enum logic [2:0] {
        K_IDLE    = 3'b001,
        K_PRESSED = 3'b010,
        K_HELD    = 3'b100
    } key_fsm_e;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Valid/ready event port carrying the key index and classified event type.
interface key_event_ctrl_if #(
    parameter int unsigned NUM_KEYS = 4
);
    localparam int unsigned KEY_W = $clog2(NUM_KEYS);

    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;
    logic [1:0]       evt_type;

    modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
    modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface

// File: rtl/key_event_fsm.sv
// One key's press/hold classifier; emits a combinational queue strobe and event type.
// Auto-repeat while held is built only when KEY_REPEAT_EN is defined.
module key_event_fsm
    import key_evt_pkg::*;
#(
    parameter int unsigned LONG_CNT   = 49_999_999,
    parameter int unsigned REPEAT_CNT = 9_999_999,
    parameter int unsigned CNT_W      = 26
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       q_c,
    output logic [1:0] q_type_c
);
    localparam int unsigned MAX_CNT = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;

    if (64'(MAX_CNT) >= (64'd1 << CNT_W)) begin : g_cnt_w_chk
        $error("key_event_fsm: CNT_W too narrow for LONG_CNT/REPEAT_CNT");
    end

    key_fsm_e         state;
    logic [CNT_W-1:0] cnt;
    logic             press_c;
    logic             rel_c;
    logic             long_hit_c;

    assign press_c    = key_flag & ~key_state;
    assign rel_c      = key_flag & key_state;
    assign long_hit_c = (cnt == CNT_W'(LONG_CNT));

`ifdef KEY_REPEAT_EN
    logic rep_hit_c;
    assign rep_hit_c = (cnt == CNT_W'(REPEAT_CNT));
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= K_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                K_IDLE: begin
                    if (press_c) begin
                        state <= K_PRESSED;
                        cnt   <= '0;
                    end
                end
                K_PRESSED: begin
                    // release wins over a coincident long threshold
                    if (rel_c) begin
                        state <= K_IDLE;
                        cnt   <= '0;
                    end else if (long_hit_c) begin
                        state <= K_HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                K_HELD: begin
                    if (rel_c) begin
                        state <= K_IDLE;
                        cnt   <= '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (rep_hit_c) cnt <= '0;
                    else                cnt <= cnt + CNT_W'(1);
`endif
                end
                default: begin
                    state <= K_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        q_c      = 1'b0;
        q_type_c = EVT_SHORT;
        case (state)
            K_PRESSED: begin
                if (rel_c) begin
                    q_c      = 1'b1;
                    q_type_c = EVT_SHORT;
                end else if (long_hit_c) begin
                    q_c      = 1'b1;
                    q_type_c = EVT_LONG;
                end
            end
            K_HELD: begin
                if (rel_c) begin
                    q_c      = 1'b1;
                    q_type_c = EVT_LONG_RELEASE;
                end
`ifdef KEY_REPEAT_EN
                else if (rep_hit_c) begin
                    q_c      = 1'b1;
                    q_type_c = EVT_REPEAT;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Per-key event classifiers, one pending slot per key and a round-robin arbiter onto a
// registered valid/ready event port. KEY_REPEAT_EN enables auto-repeat events.
module key_event_ctrl
    import key_evt_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned LONG_CNT   = 49_999_999,
    parameter int unsigned REPEAT_CNT = 9_999_999,
    parameter int unsigned CNT_W      = 26
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [NUM_KEYS-1:0] key_flag,
    input  logic [NUM_KEYS-1:0] key_state,
    key_event_ctrl_if.master    evt,
    output logic                overflow
);
    localparam int unsigned KEY_W = $clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0]      q_c;
    logic [NUM_KEYS-1:0][1:0] q_type_c;
    logic [NUM_KEYS-1:0]      pend;
    logic [NUM_KEYS-1:0][1:0] slot_type;
    logic [NUM_KEYS-1:0]      eff_c;
    logic [NUM_KEYS-1:0]      grant_c;
    logic [NUM_KEYS-1:0]      drop_c;
    logic [KEY_W-1:0]         rr_ptr;
    logic [KEY_W-1:0]         win_c;
    logic [KEY_W-1:0]         idx_c;
    logic                     found_c;
    logic                     load_c;
    logic [1:0]               win_type_c;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_event_fsm #(
            .LONG_CNT  (LONG_CNT),
            .REPEAT_CNT(REPEAT_CNT),
            .CNT_W     (CNT_W)
        ) u_fsm (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .key_flag (key_flag[g]),
            .key_state(key_state[g]),
            .q_c      (q_c[g]),
            .q_type_c (q_type_c[g])
        );
    end

    // Fresh events bypass the slot so a free port shows them the next cycle.
    assign eff_c = pend | q_c;

    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned o = 0; o < NUM_KEYS; o++) begin
            idx_c = KEY_W'((32'(rr_ptr) + o) % NUM_KEYS);
            if (!found_c && eff_c[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    assign load_c     = found_c && (!evt.evt_valid || evt.evt_ready);
    assign win_type_c = pend[win_c] ? slot_type[win_c] : q_type_c[win_c];

    always_comb begin
        grant_c = '0;
        if (load_c) grant_c[win_c] = 1'b1;
    end

    assign drop_c = q_c & pend & ~grant_c;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend          <= '0;
            slot_type     <= '0;
            rr_ptr        <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_key   <= '0;
            evt.evt_type  <= '0;
            overflow      <= 1'b0;
        end else begin
            overflow <= |drop_c;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                // a granted slot is refilled by a same-cycle event from its key
                if (grant_c[i]) begin
                    pend[i] <= pend[i] & q_c[i];
                    if (q_c[i]) slot_type[i] <= q_type_c[i];
                end else if (q_c[i] && !pend[i]) begin
                    pend[i]      <= 1'b1;
                    slot_type[i] <= q_type_c[i];
                end
            end
            if (load_c) begin
                evt.evt_valid <= 1'b1;
                evt.evt_key   <= win_c;
                evt.evt_type  <= win_type_c;
                rr_ptr        <= (32'(win_c) + 32'd1 == NUM_KEYS) ? '0 : win_c + KEY_W'(1);
            end else if (evt.evt_ready) begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed and randomized checks of key_event_ctrl against a hold-duration event model.
module tb_key_event_ctrl;
    import key_evt_pkg::*;

    localparam int NK = 4;
    localparam int L  = 100;
    localparam int RC = 20;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  key;
        logic [1:0]  typ;
    } ev_t;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [NK-1:0] key_flag;
    logic [NK-1:0] key_state;
    logic          overflow;

    int  cyc    = 0;
    int  ov_cnt = 0;
    int  tests  = 0;
    int  fails  = 0;
    int  obs_rd = 0;
    ev_t obs[$];
    ev_t exp_q[$];

    key_event_ctrl_if #(.NUM_KEYS(NK)) evt ();

    key_event_ctrl #(
        .NUM_KEYS  (NK),
        .LONG_CNT  (L),
        .REPEAT_CNT(RC),
        .CNT_W     (26)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .key_flag (key_flag),
        .key_state(key_state),
        .evt      (evt.master),
        .overflow (overflow)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        ev_t e;
        if (evt.evt_valid && evt.evt_ready) begin
            e.cyc = 32'(cyc);
            e.key = 8'(evt.evt_key);
            e.typ = evt.evt_type;
            obs.push_back(e);
        end
        if (overflow) ov_cnt <= ov_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input int c, input int k, input logic [1:0] t);
        ev_t e;
        e.cyc = 32'(c);
        e.key = 8'(k);
        e.typ = t;
        exp_q.push_back(e);
    endtask

    // Expected events for a key pressed in cycle p and released d cycles later.
    task automatic model_hold(input int k, input int p, input int d);
        if (d <= L + 1) begin
            push_exp(p + d + 1, k, EVT_SHORT);
        end else begin
            push_exp(p + L + 2, k, EVT_LONG);
            if (REP_EN)
                for (int t = p + L + 2 + RC; t < p + d; t += RC + 1) push_exp(t + 1, k, EVT_REPEAT);
            push_exp(p + d + 1, k, EVT_LONG_RELEASE);
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        n = obs.size() - obs_rd;
        chk({tag, " count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            chk({tag, " cyc"}, obs[obs_rd + i].cyc, exp_q[i].cyc);
            chk({tag, " key"}, 32'(obs[obs_rd + i].key), 32'(exp_q[i].key));
            chk({tag, " type"}, 32'(obs[obs_rd + i].typ), 32'(exp_q[i].typ));
        end
        obs_rd = obs.size();
        exp_q.delete();
    endtask

    task automatic pulse(input int k, input logic st);
        key_flag    = '0;
        key_flag[k] = 1'b1;
        key_state[k] = st;
        tick(1);
        key_flag = '0;
    endtask

    // Press key k, hold d cycles with random ignorable flag noise, release.
    task automatic do_hold(input int k, input int d);
        int p;
        int other;
        logic [NK-1:0] kf, ks;
        p = cyc;
        for (int c = 0; c <= d; c++) begin
            kf = '0;
            ks = key_state;
            if (c == 0) begin
                kf[k] = 1'b1; ks[k] = 1'b0;
            end else if (c == d) begin
                kf[k] = 1'b1; ks[k] = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                other = (k + 1 + int'($urandom_range(0, NK - 2))) % NK;
                kf[other] = 1'b1; ks[other] = 1'b1;
                if ($urandom_range(0, 1) == 1) kf[k] = 1'b1;
            end
            key_flag  = kf;
            key_state = ks;
            tick(1);
        end
        key_flag = '0;
        model_hold(k, p, d);
    endtask

    task automatic apply_reset();
        Rst_n     = 1'b0;
        key_flag  = '0;
        key_state = '1;
        tick(3);
        Rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        int s;
        int p;
        int ov_base;
        Rst_n         = 1'b0;
        key_flag      = '0;
        key_state     = '1;
        evt.evt_ready = 1'b1;
        tick(3);
        @(negedge Clk);
        chk("rst valid", 32'(evt.evt_valid), 32'd0);
        chk("rst key", 32'(evt.evt_key), 32'd0);
        chk("rst type", 32'(evt.evt_type), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        tick(2);

        do_hold(1, 50);
        tick(5);
        check_events("short");

        do_hold(0, 165);
        tick(5);
        check_events("long");

        // simultaneous releases under backpressure
        apply_reset();
        evt.evt_ready = 1'b0;
        key_flag = 4'b1101; key_state = 4'b0010;
        tick(1);
        key_flag = '0;
        tick(10);
        key_flag = 4'b1101; key_state = 4'b1111;
        tick(1);
        key_flag = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("stall hold", 32'({evt.evt_valid, evt.evt_key, evt.evt_type}),
                32'({1'b1, 2'd0, EVT_SHORT}));
        end
        @(posedge Clk); #1;
        s = cyc;
        evt.evt_ready = 1'b1;
        push_exp(s, 0, EVT_SHORT);
        push_exp(s + 1, 2, EVT_SHORT);
        push_exp(s + 2, 3, EVT_SHORT);
        tick(5);
        check_events("rr");

        // second event onto a full slot is dropped
        ov_base = ov_cnt;
        evt.evt_ready = 1'b0;
        pulse(0, 1'b0); pulse(0, 1'b1);
        pulse(2, 1'b0); pulse(2, 1'b1);
        pulse(2, 1'b0); pulse(2, 1'b1);
        tick(3);
        chk("ovf pulses", 32'(ov_cnt - ov_base), 32'd1);
        s = cyc;
        evt.evt_ready = 1'b1;
        push_exp(s, 0, EVT_SHORT);
        push_exp(s + 1, 2, EVT_SHORT);
        tick(5);
        check_events("ovf");

        // asynchronous reset while an event is stalled and key 1 is held
        evt.evt_ready = 1'b0;
        pulse(1, 1'b0);
        tick(L + 5);
        @(negedge Clk);
        chk("pre-rst evt", 32'({evt.evt_valid, evt.evt_key, evt.evt_type}),
            32'({1'b1, 2'd1, EVT_LONG}));
        #2 Rst_n = 1'b0;
        #1;
        chk("async rst", 32'({evt.evt_valid, evt.evt_key, evt.evt_type, overflow}), 32'd0);
        @(posedge Clk); #3;
        Rst_n = 1'b1;
        tick(1);
        evt.evt_ready = 1'b1;
        pulse(1, 1'b1);
        tick(150);
        check_events("rst quiet");
        do_hold(1, 10);
        tick(5);
        check_events("post rst");

        // release on the exact long threshold
        do_hold(3, L + 1);
        tick(L + 30);
        pulse(3, 1'b1);
        tick(10);
        check_events("tie");

        for (int it = 0; it < 14; it++) begin
            int k;
            int d;
            k = int'($urandom_range(0, NK - 1));
            if (it == 0)      d = L + 1;
            else if (it == 1) d = L + 2;
            else              d = int'($urandom_range(1, L + 70));
            do_hold(k, d);
            tick(4);
            check_events("rand");
        end

        p = ov_cnt;
        chk("ovf total", 32'(p), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Scheduler that sits behind a bank of per-key debouncers and turns each key's debounced edges into classified key events.
- Inputs per key: one-cycle flag pulse plus debounced level.
- Event types: short press, long press, auto-repeat, long release.
- Simultaneous events from all keys are arbitrated round-robin onto one valid/ready event port, which feeds the control FSM or CPU register block.

Parameters:
NUM_KEYS, 4, number of debounced key channels (2..8)
LONG_CNT, 49_999_999, Clk cycles held before a long-press event (1 s at 50 MHz)
REPEAT_CNT, 9_999_999, Clk cycles between auto-repeat events while held (200 ms)
CNT_W, 26, per-key hold counter width; must hold max(LONG_CNT, REPEAT_CNT)

Ports:
Clk  in  1  system clock, 50 MHz
Rst_n  in  1  asynchronous, active-low reset
key_flag  in  NUM_KEYS  per-key one-cycle pulse: debounced edge accepted
key_state  in  NUM_KEYS  per-key debounced level; 0 = pressed, 1 = released
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event when high with evt_valid
evt_key  out  $clog2(NUM_KEYS)  index of key that generated the event
evt_type  out  2  0 SHORT, 1 LONG, 2 REPEAT, 3 LONG_RELEASE
overflow  out  1  one-cycle pulse: an event was dropped

Behaviour:
- Reset (asynchronous, any time, including mid-handshake): all key FSMs to IDLE, counters 0, pending bits 0, rr pointer 0; evt_valid 0, evt_key 0, evt_type 0, overflow 0.
- A press is `key_flag[i]=1` with `key_state[i]=0`. A release is `key_flag[i]=1` with `key_state[i]=1`.
- Per-key FSM states:
  - IDLE:
    - press -> PRESSED, counter cleared.
    - Release ignored.
  - PRESSED:
    - Counter increments each cycle.
    - Release before counter == LONG_CNT -> queue SHORT, go to IDLE.
    - Counter == LONG_CNT -> queue LONG, go to HELD, counter cleared.
    - Release and counter == LONG_CNT in the same cycle -> release wins: SHORT, IDLE.
    - Repeated press ignored.
  - HELD:
    - Counter increments each cycle.
    - Counter == REPEAT_CNT -> queue REPEAT, counter cleared.
    - Release -> queue LONG_RELEASE, go to IDLE; release takes priority over a same-cycle repeat.
- Pending slot: one per key, holding the pending bit and a 2-bit type.
  - Queue to an empty slot: set the bit, store the type.
  - Queue to a full slot that is not being granted that cycle: new event dropped, old kept, overflow pulses.
  - Grant and queue on the same key in the same cycle: slot is re-filled with the new event, no overflow.
- Output register:
  - Loads when `(!evt_valid || evt_ready)` and any pending bit is set.
  - Winner is the first pending key at or after the rr pointer, wrapping NUM_KEYS-1 -> 0.
  - On load: winner's pending bit clears and the pointer moves to winner+1 (mod NUM_KEYS).
  - With nothing pending and a handshake, evt_valid drops to 0.
- Handshake rules:
  - evt_key and evt_type are stable while `evt_valid && !evt_ready`.
  - Back-to-back events are possible every cycle when ready is held high.
- Latency: event queued in cycle N -> evt_valid high in cycle N+1 when the output register is free and the key wins arbitration.
- Counters saturate at neither end: they are always cleared on a state change, and the CNT_W check is covered by a synthesis-time assertion.

Optional Feature:
KEY_REPEAT_EN
- Defined: HELD generates REPEAT events as above.
- Undefined:
  - HELD only waits for release, which still produces LONG_RELEASE.
  - REPEAT is never emitted and the repeat compare logic is not built.
  - The counter stops once LONG is issued.

Decomposition:
- Package key_evt_pkg holds:
  - event type localparams EVT_SHORT, EVT_LONG, EVT_REPEAT, EVT_LONG_RELEASE;
  - per-key state encodings K_IDLE, K_PRESSED, K_HELD (one-hot).
- Sub-module key_event_fsm, instantiated NUM_KEYS times via generate: one key's FSM and counter, outputting a queue strobe and type.
- key_event_ctrl contains the pending slots, round-robin arbiter and output register.

Test Plan:
Bench parameters: LONG_CNT=100, REPEAT_CNT=20, evt_ready=1 unless stated.
1. Key 1 press, release 50 cycles later -> one event {key=1, SHORT} one cycle after the release flag; no other events.
2. Key 0 press, hold 165 cycles, then release -> LONG at ~cycle 100, REPEAT at ~120 and ~140 (and ~160), then LONG_RELEASE one cycle after the release flag; without KEY_REPEAT_EN only LONG then LONG_RELEASE.
3. Keys 0, 2, 3 release in the same cycle with evt_ready=0 for 10 cycles, then ready=1 -> SHORT for key 0, then 2, then 3 on consecutive cycles; evt_key/evt_type held stable while stalled.
4. Key 2 SHORT pending with ready=0, then key 2 produces a second SHORT -> overflow pulses exactly 1 cycle; the first event is later delivered and the second is lost.
5. Rst_n asserted while evt_valid=1 and key 1 is in HELD -> evt_valid=0 immediately (asynchronous); after release of reset, no event appears until a new press.
6. Release flag and counter==LONG_CNT coincide on key 3 -> SHORT emitted, LONG not emitted, key 3 FSM back in IDLE.
